pipe_hazard_ctrl: RTL and testbench

// Hazard/sequencing controller for the pipelined fwrisc core. Watches the

---
 rtl/pipe_hazard_ctrl.sv | 174 +++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_hazard_ctrl
//  Purpose  : Hazard / sequencing controller for the pipelined fwrisc core.
//             Produces stall, flush and operand-forwarding controls for the
//             decode->execute and execute->mem stage registers: load-use
//             bubbles, data-memory wait, multicycle execute ops and
//             branch-redirect flushes.
//  Revision : 1.0  initial release
// ============================================================================
module pipe_hazard_ctrl #(
    parameter int FLUSH_CYCLES = 2,    // cycles flush_d stays high per taken branch (>=1)
    parameter int MEM_TIMEOUT  = 255   // max dmem wait cycles before abort; 0 = never
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       d_valid,
    input  logic [5:0] d_rs1,
    input  logic [5:0] d_rs2,
    input  logic       d_use_rs1,
    input  logic       d_use_rs2,
    input  logic       x_valid,
    input  logic [5:0] x_rd,
    input  logic       x_is_load,
    input  logic       x_is_mem,
    input  logic       x_multi,
    input  logic       x_multi_done,
    input  logic       m_valid,
    input  logic [5:0] m_rd,
    input  logic       dmem_ack,
    input  logic       br_taken,
    output logic       stall_f,
    output logic       stall_d,
    output logic       stall_x,
    output logic       flush_d,
    output logic       flush_x,
    output logic [1:0] fwd_a,
    output logic [1:0] fwd_b,
    output logic       mem_timeout,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_MULTI    = 2'd2,
        ST_FLUSH    = 2'd3
    } state_t;

    // One counter serves both the dmem wait and the flush countdown.
    localparam int c_cnt_max = (MEM_TIMEOUT > FLUSH_CYCLES) ? MEM_TIMEOUT : FLUSH_CYCLES;
    localparam int c_cnt_w   = $clog2(c_cnt_max + 1);

    localparam logic [c_cnt_w-1:0] c_cnt_one    = c_cnt_w'(1);
    localparam logic [c_cnt_w-1:0] c_cnt_zero   = '0;
    localparam logic [c_cnt_w-1:0] c_cnt_sat    = '1;
    localparam logic [c_cnt_w-1:0] c_timeout    = c_cnt_w'(MEM_TIMEOUT);
    localparam logic [c_cnt_w-1:0] c_flush_load = c_cnt_w'(FLUSH_CYCLES - 1);

    state_t             state_q, state_d;
    logic [c_cnt_w-1:0] cnt_q, cnt_d;
    logic               w_load_use;

    // A register match only counts when the destination is not x0.
    function automatic logic hit(input logic [5:0] rs, input logic [5:0] rd);
        return (rs == rd) && (rd != 6'd0);
    endfunction

    // Execute result is newer than writeback data, so it wins.
    function automatic logic [1:0] fwd_sel(input logic [5:0] rs);
        if (x_valid && !x_is_load && hit(rs, x_rd)) return 2'd1;
        else if (m_valid && hit(rs, m_rd))          return 2'd2;
        else                                        return 2'd0;
    endfunction

    assign w_load_use = d_valid && x_valid && x_is_load &&
                        ((d_use_rs1 && hit(d_rs1, x_rd)) || (d_use_rs2 && hit(d_rs2, x_rd)));

    // Report RUN during reset even before the first clock edge has landed.
    assign state = reset ? ST_RUN : state_q;

    // Operand forwarding selects, valid in every state.
    always_comb begin
        fwd_a = 2'd0;
        fwd_b = 2'd0;
        if (!reset) begin
            fwd_a = fwd_sel(d_rs1);
            fwd_b = fwd_sel(d_rs2);
        end
    end

    // Next-state, counter and pipeline control decode.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        stall_f     = 1'b0;
        stall_d     = 1'b0;
        stall_x     = 1'b0;
        flush_d     = 1'b0;
        flush_x     = 1'b0;
        mem_timeout = 1'b0;
        if (reset) begin
            state_d = ST_RUN;
            cnt_d   = c_cnt_zero;
            flush_d = 1'b1;
            flush_x = 1'b1;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (x_valid && x_is_mem && !dmem_ack) begin
                        {stall_f, stall_d, stall_x} = 3'b111;
                        state_d = ST_MEM_WAIT;
                        cnt_d   = c_cnt_one;
                    end else if (x_valid && x_multi) begin
                        {stall_f, stall_d, stall_x} = 3'b111;
                        state_d = ST_MULTI;
                    end else if (br_taken) begin
                        flush_d = 1'b1;
                        if (FLUSH_CYCLES > 1) begin
                            state_d = ST_FLUSH;
                            cnt_d   = c_flush_load;
                        end
                    end else if (w_load_use) begin
                        // Hold decode, push a bubble behind the load.
                        stall_f = 1'b1;
                        stall_d = 1'b1;
                        flush_x = 1'b1;
                    end
                end
                ST_MEM_WAIT: begin
                    if (dmem_ack) begin
                        state_d = ST_RUN;
                        cnt_d   = c_cnt_zero;
                    end else if ((MEM_TIMEOUT != 0) && (cnt_q == c_timeout)) begin
                        mem_timeout = 1'b1;
                        flush_d     = 1'b1;
                        flush_x     = 1'b1;
                        state_d     = ST_RUN;
                        cnt_d       = c_cnt_zero;
                    end else begin
                        {stall_f, stall_d, stall_x} = 3'b111;
                        if (cnt_q != c_cnt_sat) cnt_d = cnt_q + c_cnt_one;
                    end
                end
                ST_MULTI: begin
                    if (x_multi_done) begin
                        state_d = ST_RUN;
                    end else begin
                        {stall_f, stall_d, stall_x} = 3'b111;
                    end
                end
                default: begin  // ST_FLUSH
                    flush_d = 1'b1;
                    if (br_taken) begin
                        cnt_d = c_flush_load;
                    end else if (cnt_q <= c_cnt_one) begin
                        cnt_d   = c_cnt_zero;
                        state_d = ST_RUN;
                    end else begin
                        cnt_d = cnt_q - c_cnt_one;
                    end
                end
            endcase
        end
    end

    // State and counter registers.
    always_ff @(posedge clock) begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
    end

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipe_hazard_ctrl
//  Purpose  : Self-checking bench for pipe_hazard_ctrl. Two instances with
//             different parameters share one stimulus stream and are compared
//             every cycle against a behavioural model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

    logic       clock = 1'b0;
    logic       reset;
    logic       d_valid, d_use_rs1, d_use_rs2;
    logic [5:0] d_rs1, d_rs2, x_rd, m_rd;
    logic       x_valid, x_is_load, x_is_mem, x_multi, x_multi_done;
    logic       m_valid, dmem_ack, br_taken;

    logic       stall_f0, stall_d0, stall_x0, flush_d0, flush_x0, mem_timeout0;
    logic [1:0] fwd_a0, fwd_b0, state0;
    logic       stall_f1, stall_d1, stall_x1, flush_d1, flush_x1, mem_timeout1;
    logic [1:0] fwd_a1, fwd_b1, state1;

    logic [11:0] o0, o1;
    assign o0 = {stall_f0, stall_d0, stall_x0, flush_d0, flush_x0, fwd_a0, fwd_b0, mem_timeout0, state0};
    assign o1 = {stall_f1, stall_d1, stall_x1, flush_d1, flush_x1, fwd_a1, fwd_b1, mem_timeout1, state1};

    int cmp_n = 0;
    int mis_n = 0;

    // Instance 0: defaults. Instance 1: single flush cycle, short timeout.
    int fc_v[2] = '{2, 1};
    int mt_v[2] = '{255, 3};

    // Model state per instance: waiting on memory (with cycles waited so far),
    // busy in a multicycle op, and flush cycles still owed after this one.
    bit md_mem[2];
    int md_wait[2];
    bit md_multi[2];
    int md_fl[2];

    always #5 clock = ~clock;

    pipe_hazard_ctrl #(.FLUSH_CYCLES(2), .MEM_TIMEOUT(255)) u0 (
        .clock(clock), .reset(reset), .d_valid(d_valid), .d_rs1(d_rs1), .d_rs2(d_rs2),
        .d_use_rs1(d_use_rs1), .d_use_rs2(d_use_rs2), .x_valid(x_valid), .x_rd(x_rd),
        .x_is_load(x_is_load), .x_is_mem(x_is_mem), .x_multi(x_multi),
        .x_multi_done(x_multi_done), .m_valid(m_valid), .m_rd(m_rd), .dmem_ack(dmem_ack),
        .br_taken(br_taken), .stall_f(stall_f0), .stall_d(stall_d0), .stall_x(stall_x0),
        .flush_d(flush_d0), .flush_x(flush_x0), .fwd_a(fwd_a0), .fwd_b(fwd_b0),
        .mem_timeout(mem_timeout0), .state(state0));

    pipe_hazard_ctrl #(.FLUSH_CYCLES(1), .MEM_TIMEOUT(3)) u1 (
        .clock(clock), .reset(reset), .d_valid(d_valid), .d_rs1(d_rs1), .d_rs2(d_rs2),
        .d_use_rs1(d_use_rs1), .d_use_rs2(d_use_rs2), .x_valid(x_valid), .x_rd(x_rd),
        .x_is_load(x_is_load), .x_is_mem(x_is_mem), .x_multi(x_multi),
        .x_multi_done(x_multi_done), .m_valid(m_valid), .m_rd(m_rd), .dmem_ack(dmem_ack),
        .br_taken(br_taken), .stall_f(stall_f1), .stall_d(stall_d1), .stall_x(stall_x1),
        .flush_d(flush_d1), .flush_x(flush_x1), .fwd_a(fwd_a1), .fwd_b(fwd_b1),
        .mem_timeout(mem_timeout1), .state(state1));

    task automatic chk(input string tag, input logic [11:0] got, input logic [11:0] exp);
        cmp_n++;
        assert (got === exp) else begin
            mis_n++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] ref_fwd(input logic [5:0] rs);
        if (x_valid && !x_is_load && x_rd != 0 && rs == x_rd) return 2'd1;
        if (m_valid && m_rd != 0 && rs == m_rd)               return 2'd2;
        return 2'd0;
    endfunction

    function automatic logic [11:0] expect_out(input int k);
        logic sf, sd, sx, fd, fx, to;
        logic [1:0] fa, fb, st;
        logic load_use;
        {sf, sd, sx, fd, fx, to} = 6'b0;
        fa = 0; fb = 0; st = 0;
        load_use = d_valid && x_valid && x_is_load &&
                   ((d_use_rs1 && x_rd != 0 && d_rs1 == x_rd) ||
                    (d_use_rs2 && x_rd != 0 && d_rs2 == x_rd));
        if (reset) begin
            fd = 1; fx = 1;
        end else begin
            fa = ref_fwd(d_rs1);
            fb = ref_fwd(d_rs2);
            st = md_mem[k] ? 2'd1 : md_multi[k] ? 2'd2 : (md_fl[k] > 0) ? 2'd3 : 2'd0;
            if (md_mem[k]) begin
                if (dmem_ack) ;
                else if (mt_v[k] != 0 && md_wait[k] == mt_v[k]) begin to = 1; fd = 1; fx = 1; end
                else begin sf = 1; sd = 1; sx = 1; end
            end else if (md_multi[k]) begin
                if (!x_multi_done) begin sf = 1; sd = 1; sx = 1; end
            end else if (md_fl[k] > 0) begin
                fd = 1;
            end else if (x_valid && x_is_mem && !dmem_ack) begin
                sf = 1; sd = 1; sx = 1;
            end else if (x_valid && x_multi) begin
                sf = 1; sd = 1; sx = 1;
            end else if (br_taken) begin
                fd = 1;
            end else if (load_use) begin
                sf = 1; sd = 1; fx = 1;
            end
        end
        return {sf, sd, sx, fd, fx, fa, fb, to, st};
    endfunction

    task automatic update_model();
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                md_mem[k] = 0; md_wait[k] = 0; md_multi[k] = 0; md_fl[k] = 0;
            end else if (md_mem[k]) begin
                if (dmem_ack || (mt_v[k] != 0 && md_wait[k] == mt_v[k])) md_mem[k] = 0;
                else md_wait[k]++;
            end else if (md_multi[k]) begin
                if (x_multi_done) md_multi[k] = 0;
            end else if (md_fl[k] > 0) begin
                md_fl[k] = br_taken ? fc_v[k] - 1 : md_fl[k] - 1;
            end else if (x_valid && x_is_mem && !dmem_ack) begin
                md_mem[k] = 1; md_wait[k] = 1;
            end else if (x_valid && x_multi) begin
                md_multi[k] = 1;
            end else if (br_taken) begin
                md_fl[k] = fc_v[k] - 1;
            end
        end
    endtask

    string fname[9] = '{"stall_f", "stall_d", "stall_x", "flush_d", "flush_x",
                        "fwd_a", "fwd_b", "mem_timeout", "state"};
    int    flsb[9]  = '{11, 10, 9, 8, 7, 5, 3, 2, 0};
    int    fwid[9]  = '{1, 1, 1, 1, 1, 2, 2, 1, 2};

    task automatic check_all();
        logic [11:0] obs, exp, mask;
        for (int k = 0; k < 2; k++) begin
            obs = (k == 0) ? o0 : o1;
            exp = expect_out(k);
            for (int f = 0; f < 9; f++) begin
                mask = (12'd1 << fwid[f]) - 12'd1;
                chk($sformatf("u%0d.%s", k, fname[f]), (obs >> flsb[f]) & mask,
                    (exp >> flsb[f]) & mask);
            end
        end
    endtask

    // Inputs are driven at the falling edge; check, then advance one cycle.
    task automatic cyc();
        #1;
        check_all();
        @(posedge clock);
        update_model();
        @(negedge clock);
    endtask

    task automatic clear_inputs();
        d_valid = 0; d_rs1 = 0; d_rs2 = 0; d_use_rs1 = 0; d_use_rs2 = 0;
        x_valid = 0; x_rd = 0; x_is_load = 0; x_is_mem = 0; x_multi = 0;
        x_multi_done = 0; m_valid = 0; m_rd = 0; dmem_ack = 0; br_taken = 0;
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            md_mem[k] = 0; md_wait[k] = 0; md_multi[k] = 0; md_fl[k] = 0;
        end
        clear_inputs();
        reset = 1;
        @(negedge clock);

        // Reset held three cycles.
        #1 chk("rst_flush_d", flush_d0, 1);
        chk("rst_state", state0, 0);
        cyc(); cyc(); cyc();
        reset = 0;
        #1 chk("run_idle_flush", flush_d0, 0);
        cyc();

        // Load-use on rs2, then writeback forward.
        x_valid = 1; x_is_load = 1; x_rd = 5; d_valid = 1; d_use_rs2 = 1; d_rs2 = 5;
        #1 chk("lu_stall_d", stall_d0, 1);
        chk("lu_flush_x", flush_x0, 1);
        cyc();
        x_valid = 0; x_is_load = 0; m_valid = 1; m_rd = 5;
        #1 chk("lu_fwd_b", fwd_b0, 2);
        chk("lu_release", stall_d0, 0);
        cyc();

        // Memory wait: ack in cycle 4; u1 times out in cycle 3.
        clear_inputs();
        x_valid = 1; x_is_mem = 1;
        cyc();
        #1 chk("mw_state", state0, 1);
        cyc(); cyc();
        #1 chk("mw_timeout", mem_timeout1, 1);
        chk("mw_stall_c3", stall_x0, 1);
        cyc();
        dmem_ack = 1;
        #1 chk("mw_ack_drop", stall_f0, 0);
        cyc();

        // Multicycle op with a branch that must be ignored.
        clear_inputs();
        x_valid = 1; x_multi = 1;
        cyc(); cyc();
        br_taken = 1;
        #1 chk("mc_br_noflush", flush_d0, 0);
        chk("mc_state", state0, 2);
        cyc();
        br_taken = 0;
        cyc(); cyc(); cyc();
        x_valid = 0; x_multi = 0; x_multi_done = 1;
        #1 chk("mc_done_drop", stall_x0, 0);
        cyc();

        // Branch flush, then a second branch extending it.
        clear_inputs();
        br_taken = 1;
        cyc(); cyc();
        br_taken = 0;
        #1 chk("fl_extended", flush_d0, 1);
        cyc();
        #1 chk("fl_done", flush_d0, 0);
        cyc();

        // x0 never hazards; execute forward beats writeback.
        x_valid = 1; x_is_load = 1; x_rd = 0; d_valid = 1; d_use_rs1 = 1; d_rs1 = 0;
        #1 chk("x0_nostall", stall_d0, 0);
        chk("x0_fwd_a", fwd_a0, 0);
        cyc();
        x_is_load = 0; x_rd = 7; m_valid = 1; m_rd = 7; d_rs1 = 7;
        #1 chk("fwd_x_wins", fwd_a0, 1);
        cyc();

        // Randomised traffic, including occasional mid-operation resets.
        for (int i = 0; i < 3000; i++) begin
            reset        = ($urandom_range(0, 59) == 0);
            d_valid      = ($urandom_range(0, 3) != 0);
            d_rs1        = 6'($urandom_range(0, 7));
            d_rs2        = 6'($urandom_range(0, 7));
            d_use_rs1    = $urandom_range(0, 1) == 1;
            d_use_rs2    = $urandom_range(0, 1) == 1;
            x_valid      = ($urandom_range(0, 3) != 0);
            x_rd         = 6'($urandom_range(0, 7));
            x_is_load    = ($urandom_range(0, 2) == 0);
            x_is_mem     = x_is_load || ($urandom_range(0, 5) == 0);
            x_multi      = ($urandom_range(0, 7) == 0);
            x_multi_done = ($urandom_range(0, 4) == 0);
            m_valid      = $urandom_range(0, 1) == 1;
            m_rd         = 6'($urandom_range(0, 7));
            dmem_ack     = ($urandom_range(0, 3) == 0);
            br_taken     = ($urandom_range(0, 5) == 0);
            cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, mis_n);
        $finish;
    end

endmodule
`default_nettype wire
